// File: rtl/prog_sequencer.sv
// rtl/prog_sequencer.sv - instruction-memory sequencer feeding DIN/Run to the mv/mvi/add/sub processor
module prog_sequencer #(
  parameter int AW  = 4,
  parameter int TMO = 7
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          Start,
  input  logic          StepMode,
  input  logic          Step,
  input  logic          WrEn,
  input  logic [AW-1:0] WrAddr,
  input  logic [15:0]   WrData,
  input  logic          Done,
  output logic [15:0]   DIN,
  output logic          Run,
  output logic [AW-1:0] PC,
  output logic          Busy,
  output logic          Halted,
  output logic          Error,
  output logic [7:0]    InstrCount
);

  localparam int CW = $clog2(TMO + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_PAUSE,
    S_HALTED,
    S_ERR
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   pc_q, pc_d;
  logic [7:0]      icnt_q, icnt_d;
  logic [CW-1:0]   tmo_q, tmo_d;
  logic [15:0]     mem_q [0:(1<<AW)-1];

  logic [15:0]     cur_word;
  logic [AW-1:0]   pc_p1, pc_p2;
  logic            is_mvi, is_halt, busy;

  assign pc_p1    = pc_q + AW'(1);
  assign pc_p2    = pc_q + AW'(2);
  assign cur_word = mem_q[pc_q];
  assign is_mvi   = (cur_word[15:13] == 3'b001);
  assign is_halt  = (cur_word[15:13] == 3'b111);
  assign busy     = (state_q == S_FETCH) || (state_q == S_EXEC) || (state_q == S_PAUSE);

  // Program memory is only writable while the sequencer is not driving the processor.
  always_ff @(posedge Clock) begin
    if (WrEn && !busy) begin
      mem_q[WrAddr] <= WrData;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    icnt_d  = icnt_q;
    tmo_d   = tmo_q;
    case (state_q)
      S_IDLE, S_HALTED: begin
        if (Start) begin
          state_d = S_FETCH;
          pc_d    = '0;
          icnt_d  = '0;
        end
      end
      S_FETCH: begin
        if (is_halt) begin
          state_d = S_HALTED;
        end else begin
          state_d = S_EXEC;
          tmo_d   = '0;
        end
      end
      S_EXEC: begin
        // Done on the same edge as the timeout limit still retires.
        if (Done) begin
          pc_d    = is_mvi ? pc_p2 : pc_p1;
          icnt_d  = (icnt_q == 8'hFF) ? icnt_q : icnt_q + 8'd1;
          state_d = StepMode ? S_PAUSE : S_FETCH;
        end else if (tmo_q == CW'(TMO - 1)) begin
          state_d = S_ERR;
        end else begin
          tmo_d = tmo_q + CW'(1);
        end
      end
      S_PAUSE: begin
        if (Step) begin
          state_d = S_FETCH;
        end
      end
      S_ERR:   state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      icnt_q  <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      icnt_q  <= icnt_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    Run = 1'b0;
    DIN = 16'h0000;
    case (state_q)
      S_FETCH: begin
        if (!is_halt) begin
          Run = 1'b1;
          DIN = cur_word;
        end
      end
      S_EXEC: begin
        Run = 1'b1;
        DIN = is_mvi ? mem_q[pc_p1] : 16'h0000;
      end
      default: begin
        Run = 1'b0;
        DIN = 16'h0000;
      end
    endcase
  end

  assign PC         = pc_q;
  assign Busy       = busy;
  assign Halted     = (state_q == S_HALTED);
  assign Error      = (state_q == S_ERR);
  assign InstrCount = icnt_q;

endmodule

// File: doc/prog_sequencer.md
# prog_sequencer

Program sequencer for the 16-bit mv/mvi/add/sub processor. It holds a small instruction memory, presents each instruction word (and the mvi immediate) on the processor's DIN, and asserts Run. It then waits for the processor's Done before advancing the program counter, and supports free-run and single-step modes, a HALT opcode and a Done-timeout error. It sits between the board switches/keys and the processor, replacing manual SW/Run entry.

## Interface
Parameters:
- AW, 4, program memory address width (depth 2^AW words)
- TMO, 7, maximum EXEC cycles allowed without Done before error

Ports:
- Clock  in  1  system clock, all state updates on rising edge
- Reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- Start  in  1  begin execution from PC=0 (level sampled each cycle)
- StepMode  in  1  1 = pause after every retired instruction
- Step  in  1  resume from PAUSE (one instruction per cycle it is sampled high in PAUSE)
- WrEn  in  1  program memory write strobe
- WrAddr  in  AW  program memory write address
- WrData  in  16  program memory write data
- Done  in  1  processor instruction-complete flag (combinational from processor)
- DIN  out  16  word driven to processor DIN
- Run  out  1  processor Run
- PC  out  AW  address of current instruction
- Busy  out  1  high in FETCH, EXEC, PAUSE
- Halted  out  1  high in HALTED
- Error  out  1  high in ERR
- InstrCount  out  8  retired instructions, saturates at 255

## Operation
- Memory: 2^AW x 16 register array; synchronous write when WrEn && !Busy; writes while Busy are ignored; combinational read; not cleared by Reset.
- Opcode = word[15:13]; 001 = mvi (two words); 111 = HALT (sequencer only, never issued); all others one word.
- States: IDLE, FETCH, EXEC, PAUSE, HALTED, ERR.
- IDLE: Start=1 -> FETCH, PC<=0, InstrCount<=0.
- FETCH (1 cycle): if opcode(mem[PC])==111 -> HALTED, Run=0. Otherwise DIN=mem[PC], Run=1, tmo counter<=0 -> EXEC.
- EXEC: Run=1; DIN=mem[PC+1] if opcode mvi else 16'h0000. Each cycle with Done=0: counter+1; when counter reaches TMO -> ERR. Done=1: retire; PC<=PC+2 (mvi) or PC+1; InstrCount+1 (saturating); -> PAUSE if StepMode else FETCH.
- PAUSE: Run=0, DIN=0; Step=1 -> FETCH.
- HALTED: Start=1 -> FETCH with PC<=0, InstrCount<=0.
- ERR: sticky; only Reset leaves it.
- PC arithmetic is modulo 2^AW: mvi at the last address takes its immediate from address 0. PC+2 wraps the same way.

## Timing
- Reset values: state IDLE, PC=0, DIN=0, Run=0, Busy=0, Halted=0, Error=0, InstrCount=0, counter=0.
- Reset asserted in any state returns to IDLE on the next edge, overriding Start, Step, Done and WrEn. A write coinciding with Reset is still performed if state is not Busy.
- Start -> first Run high: 1 cycle (the IDLE edge), then Run high in FETCH.
- Processor T0 coincides with FETCH and T1 with the first EXEC cycle. mv/mvi retire after 1 EXEC cycle, add/sub after 3, giving minimum instruction periods of 2 and 4 cycles.
- Done is ignored outside EXEC.
- Done sampled on the same edge the counter would reach TMO: Done wins (retire).
- Start while Busy is ignored. Step outside PAUSE is ignored. StepMode is sampled only at retirement.
- Outputs are Moore functions of state, PC and memory; there is no combinational path from Done to Run/DIN.

## Test plan
- Reset, write mem[0]=16'h2000 (mvi R0), mem[1]=16'h0005, mem[2]=16'hE000, Start, Done model pulses on first EXEC cycle. Required: DIN 2000 then 0005 with Run=1; PC 0->2; Halted=1; InstrCount=1.
- Program add R0,R1 (16'h4080) with Done after 3 EXEC cycles. Required: Run high 4 cycles; PC 0->1.
- Done never asserted. Required: Error=1 after exactly TMO EXEC cycles, Run=0. Start is ignored. Reset returns to IDLE.
- StepMode=1, three mv words then HALT. Required: PAUSE after each retirement; each Step pulse advances PC by 1; Halted after the third Step.
- mvi at address 15 (AW=4), immediate at mem[0]. Required: DIN=mem[0] in EXEC; PC wraps to 1.
- WrEn during EXEC to the current PC+1. Required: memory unchanged. Reset asserted mid-EXEC: next cycle IDLE, Run=0, PC=0, memory contents preserved.
